// File: rtl/fc_host_port.sv
// Host-side staging port: streams an N-word x vector to an accelerator and captures its M-word result.
// Optional build macro: FC_HOST_PORT_STALL_INJECT_EN (periodic rx_ready stall, 1 cycle in 4).
module fc_host_port #(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int M     = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    host_wr_en,
  input  logic [$clog2(N)-1:0]    host_addr,
  input  logic signed [WIDTH-1:0] host_wdata,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic signed [WIDTH-1:0] tx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  input  logic signed [WIDTH-1:0] rx_data,
  input  logic [$clog2(M)-1:0]    res_addr,
  output logic signed [WIDTH-1:0] res_rdata,
  output logic [1:0]              state_dbg   // 0 IDLE, 1 SEND, 2 RECV, 3 DONE
);

  localparam int XAW = $clog2(N);
  localparam int RAW = $clog2(M);
  localparam logic [XAW-1:0] TX_LAST = XAW'(N - 1);
  localparam logic [RAW-1:0] RX_LAST = RAW'(M - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [XAW-1:0]          tx_idx;
  logic [RAW-1:0]          rx_idx;
  logic signed [WIDTH-1:0] x_mem [N];
  logic signed [WIDTH-1:0] result_mem [M];
  logic                    tx_fire;
  logic                    rx_fire;
  logic                    rx_open;

  // Handshakes: a word moves on a cycle where valid && ready are both 1 at posedge;
  // valid never depends on ready, and the offered data is held until it moves.

`ifdef FC_HOST_PORT_STALL_INJECT_EN
  logic [1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= 2'd0;
    else       stall_cnt <= stall_cnt + 2'd1;
  end

  assign rx_open = (stall_cnt != 2'd3);
`else
  assign rx_open = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    tx_valid  = 1'b0;
    rx_ready  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready && tx_idx == TX_LAST) state_nxt = RECV;
      end
      RECV: begin
        rx_ready = rx_open;
        if (rx_valid && rx_open && rx_idx == RX_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_fire   = tx_valid && tx_ready;
  assign rx_fire   = rx_valid && rx_ready;
  assign tx_data   = tx_valid ? x_mem[tx_idx] : '0;
  assign state_dbg = state;

  // Indices saturate at the last slot; the state change ends the phase instead of a wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_idx <= '0;
      rx_idx <= '0;
    end else if (state == IDLE && start) begin
      tx_idx <= '0;
      rx_idx <= '0;
    end else begin
      if (tx_fire && tx_idx != TX_LAST) tx_idx <= tx_idx + XAW'(1);
      if (rx_fire && rx_idx != RX_LAST) rx_idx <= rx_idx + RAW'(1);
    end
  end

  // Buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    if (host_wr_en && !busy) x_mem[host_addr] <= host_wdata;
  end

  always_ff @(posedge clk) begin
    if (rx_fire) result_mem[rx_idx] <= rx_data;
    res_rdata <= result_mem[res_addr];
  end

endmodule

// File: tb/tb_fc_host_port.sv
// Bench for fc_host_port: random jobs against a queue/array model of the x and result buffers.
// Build with FC_HOST_PORT_STALL_INJECT_EN to check the stall pattern instead of continuous rx_ready.
`timescale 1ns/1ps
module tb_fc_host_port;
  localparam int WIDTH = 16;
  localparam int N     = 8;
  localparam int M     = 10;
  localparam int BUDGET = 400;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    host_wr_en = 1'b0;
  logic [$clog2(N)-1:0]    host_addr = '0;
  logic signed [WIDTH-1:0] host_wdata = '0;
  logic                    start = 1'b0;
  logic                    busy, done, tx_valid, rx_ready;
  logic                    tx_ready = 1'b0;
  logic signed [WIDTH-1:0] tx_data;
  logic                    rx_valid = 1'b0;
  logic signed [WIDTH-1:0] rx_data = '0;
  logic [$clog2(M)-1:0]    res_addr = '0;
  logic signed [WIDTH-1:0] res_rdata;
  logic [1:0]              state_dbg;

  fc_host_port #(.WIDTH(WIDTH), .N(N), .M(M)) dut (
    .clk(clk), .reset(reset),
    .host_wr_en(host_wr_en), .host_addr(host_addr), .host_wdata(host_wdata),
    .start(start), .busy(busy), .done(done),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .res_addr(res_addr), .res_rdata(res_rdata), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model and scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] x_m   [N];
  logic [WIDTH-1:0] res_m [M];
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] got_tx[$];
  logic [WIDTH-1:0] got_rx[$];
  logic [WIDTH-1:0] rx_q  [$];
  int stall_cyc[$];
  int done_cnt, hold_err, rx_bad, extra_tx, first_tx, last_tx, last_cap, done_cyc;
  bit timed_out;
  logic [1:0] end_state;
  logic end_valid, end_rx_ready;

  // ---------------- driver tasks ----------------
  task automatic write_x(input int addr, input logic [WIDTH-1:0] val);
    @(negedge clk);
    host_wr_en = 1'b1;
    host_addr  = addr[$clog2(N)-1:0];
    host_wdata = val;
    @(negedge clk);
    host_wr_en = 1'b0;
    x_m[addr]  = val;
  endtask

  task automatic fill_rx(input int base, input bit rnd);
    rx_q.delete();
    for (int i = 0; i < M + 4; i++)
      rx_q.push_back(rnd ? WIDTH'($urandom) : WIDTH'(base + i));
  endtask

  task automatic read_res(input int addr);
    @(negedge clk);
    res_addr = addr[$clog2(M)-1:0];
    @(negedge clk);
  endtask

  // One full job: tx_mode 0 always-ready, 1 toggling, 2 random; rx_mode 0 always-valid, 1 random.
  task automatic do_job(input int tx_mode, input int rx_mode, input bit inject,
                        input bit wr_start, input logic [WIDTH-1:0] wr_val);
    int rx_sent;
    bit pend, in_recv, injected;
    logic [WIDTH-1:0] held;
    got_tx.delete(); got_rx.delete(); stall_cyc.delete(); exp_q.delete();
    done_cnt = 0; hold_err = 0; rx_bad = 0; extra_tx = 0; timed_out = 1'b0;
    first_tx = -1; last_tx = -1; last_cap = -1; done_cyc = -1;
    end_state = 2'd0; end_valid = 1'b1; end_rx_ready = 1'b0;
    rx_sent = 0; pend = 1'b0; injected = 1'b0; held = '0;
    @(negedge clk);
    start = 1'b1;
    if (wr_start) begin
      host_wr_en = 1'b1; host_addr = '0; host_wdata = wr_val; x_m[0] = wr_val;
    end
    for (int i = 0; i < N; i++) exp_q.push_back(x_m[i]);
    @(negedge clk);
    start = 1'b0; host_wr_en = 1'b0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      case (tx_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 2 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      rx_valid = (rx_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      rx_data  = rx_q[(rx_sent < rx_q.size()) ? rx_sent : rx_q.size() - 1];
      in_recv  = (got_tx.size() == N) && (cyc > last_tx) && (got_rx.size() < M);
      if (inject && in_recv && !injected) begin
        start = 1'b1; host_wr_en = 1'b1; host_addr = 3; host_wdata = -16'sd5; injected = 1'b1;
      end else begin
        start = 1'b0; host_wr_en = 1'b0;
      end
      if (got_tx.size() == N && cyc == last_tx + 1) begin
        end_state = state_dbg; end_valid = tx_valid; end_rx_ready = rx_ready;
      end
      if (tx_valid) begin
        if (pend && tx_data !== held) hold_err++;
        if (got_tx.size() >= N) extra_tx++;
        if (tx_ready) begin
          got_tx.push_back(tx_data);
          if (first_tx < 0) first_tx = cyc;
          last_tx = cyc; pend = 1'b0;
        end else begin
          pend = 1'b1; held = tx_data;
        end
      end
      if (rx_ready && got_tx.size() < N) rx_bad++;
      if (in_recv && rx_valid && !rx_ready) stall_cyc.push_back(cyc);
      if (rx_valid && rx_ready) begin
        if (got_rx.size() >= M) rx_bad++;
        else begin
          got_rx.push_back(rx_data);
          res_m[got_rx.size() - 1] = rx_data;
          last_cap = cyc;
        end
        rx_sent++;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
    end
    if (done_cyc < 0) timed_out = 1'b1;
    tx_ready = 1'b0; rx_valid = 1'b0; start = 1'b0; host_wr_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); end
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL reset_rx_ready got=%0b exp=0", rx_ready); end
    checks++; if (tx_data !== '0) begin failures++; $display("FAIL reset_tx_data got=%0d exp=0", tx_data); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_job;
    logic [WIDTH-1:0] e;
    for (int i = 0; i < N; i++) write_x(i, WIDTH'(i + 1));
    fill_rx(100, 1'b0);
    do_job(0, 0, 1'b0, 1'b0, '0);
    checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout got=no_done exp=done"); end
    checks++; if (got_tx.size() !== N) begin failures++; $display("FAIL basic_tx_count got=%0d exp=%0d", got_tx.size(), N); end
    for (int i = 0; i < got_tx.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++; if (got_tx[i] !== e) begin failures++; $display("FAIL basic_tx_word%0d got=%0d exp=%0d", i, got_tx[i], e); end
    end
    checks++; if (first_tx !== 0 || last_tx - first_tx !== N - 1) begin
      failures++; $display("FAIL basic_tx_consecutive got=%0d..%0d exp=0..%0d", first_tx, last_tx, N - 1); end
    checks++; if (end_valid !== 1'b0 || end_state !== 2'd2) begin
      failures++; $display("FAIL basic_after_send got=valid%0b_state%0d exp=valid0_state2", end_valid, end_state); end
`ifndef FC_HOST_PORT_STALL_INJECT_EN
    checks++; if (end_rx_ready !== 1'b1) begin failures++; $display("FAIL basic_recv_ready got=%0b exp=1", end_rx_ready); end
`endif
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    checks++; if (done_cyc !== last_cap + 1) begin failures++; $display("FAIL basic_done_timing got=%0d exp=%0d", done_cyc, last_cap + 1); end
    checks++; if (rx_bad !== 0 || extra_tx !== 0) begin failures++; $display("FAIL basic_spurious got=rx%0d_tx%0d exp=0_0", rx_bad, extra_tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%0b exp=0", busy); end
    for (int k = 0; k < M; k++) begin
      read_res(k);
      checks++; if (res_rdata !== WIDTH'(100 + k)) begin
        failures++; $display("FAIL basic_res%0d got=%0d exp=%0d", k, res_rdata, 100 + k); end
    end
  endtask

  task automatic test_tx_backpressure;
    logic [WIDTH-1:0] e;
    for (int i = 0; i < N; i++) write_x(i, WIDTH'($urandom));
    fill_rx(0, 1'b1);
    do_job(1, 0, 1'b0, 1'b0, '0);
    checks++; if (timed_out) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
    checks++; if (got_tx.size() !== N) begin failures++; $display("FAIL bp_tx_count got=%0d exp=%0d", got_tx.size(), N); end
    checks++; if (hold_err !== 0) begin failures++; $display("FAIL bp_hold got=%0d exp=0", hold_err); end
    for (int i = 0; i < got_tx.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++; if (got_tx[i] !== e) begin failures++; $display("FAIL bp_tx_word%0d got=%0d exp=%0d", i, got_tx[i], e); end
    end
  endtask

  task automatic test_ignore_when_busy;
    logic [WIDTH-1:0] e;
    fill_rx(0, 1'b1);
    do_job(0, 0, 1'b1, 1'b0, '0);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_restart got=%0b exp=0", busy); end
    fill_rx(0, 1'b1);
    do_job(2, 1, 1'b0, 1'b0, '0);
    checks++; if (got_tx.size() !== N) begin failures++; $display("FAIL busy_tx_count got=%0d exp=%0d", got_tx.size(), N); end
    for (int i = 0; i < got_tx.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++; if (got_tx[i] !== e) begin failures++; $display("FAIL busy_tx_word%0d got=%0d exp=%0d", i, got_tx[i], e); end
    end
  endtask

  task automatic test_reset_mid_send;
    int n;
    int extra_done;
    bit hit;
    logic [WIDTH-1:0] e;
    n = 0; hit = 1'b0; extra_done = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; tx_ready = 1'b1;
    for (int c = 0; c < 50 && !hit; c++) begin
      if (tx_valid && tx_ready) begin
        n++;
        if (n == 5) begin
          reset = 1'b1; hit = 1'b1;
          checks++; if (tx_data !== x_m[4]) begin failures++; $display("FAIL rst_fifth_word got=%0d exp=%0d", tx_data, x_m[4]); end
        end
      end
      @(negedge clk);
    end
    reset = 1'b0; tx_ready = 1'b0;
    checks++; if (!hit) begin failures++; $display("FAIL rst_reach_fifth got=%0d exp=5", n); end
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_abort got=valid%0b_busy%0b exp=valid0_busy0", tx_valid, busy); end
    for (int c = 0; c < 10; c++) begin
      if (done) extra_done++;
      @(negedge clk);
    end
    checks++; if (extra_done !== 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", extra_done); end
    fill_rx(0, 1'b1);
    do_job(0, 0, 1'b0, 1'b0, '0);
    checks++; if (got_tx.size() !== N) begin failures++; $display("FAIL rst_resend_count got=%0d exp=%0d", got_tx.size(), N); end
    for (int i = 0; i < got_tx.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++; if (got_tx[i] !== e) begin failures++; $display("FAIL rst_resend_word%0d got=%0d exp=%0d", i, got_tx[i], e); end
    end
  endtask

  task automatic test_write_with_start;
    logic [WIDTH-1:0] v;
    v = WIDTH'($urandom);
    fill_rx(0, 1'b1);
    do_job(0, 0, 1'b0, 1'b1, v);
    checks++; if (got_tx.size() < 1 || got_tx[0] !== v) begin
      failures++; $display("FAIL wr_start_word0 got=%0d exp=%0d", (got_tx.size() > 0) ? got_tx[0] : '0, v); end
  endtask

  task automatic test_rx_stall;
    bit bad_gap;
    fill_rx(0, 1'b1);
    do_job(0, 0, 1'b0, 1'b0, '0);
    checks++; if (got_rx.size() !== M || done_cnt !== 1) begin
      failures++; $display("FAIL stall_capture got=%0d_done%0d exp=%0d_done1", got_rx.size(), done_cnt, M); end
    for (int i = 0; i < got_rx.size(); i++) begin
      checks++; if (got_rx[i] !== rx_q[i]) begin failures++; $display("FAIL stall_order%0d got=%0d exp=%0d", i, got_rx[i], rx_q[i]); end
    end
`ifdef FC_HOST_PORT_STALL_INJECT_EN
    bad_gap = 1'b0;
    for (int i = 1; i < stall_cyc.size(); i++) if (stall_cyc[i] - stall_cyc[i-1] != 4) bad_gap = 1'b1;
    checks++; if (stall_cyc.size() < 2 || bad_gap) begin
      failures++; $display("FAIL stall_pattern got=%0d_stalls_badgap%0b exp=every4", stall_cyc.size(), bad_gap); end
`else
    bad_gap = 1'b0;
    checks++; if (stall_cyc.size() !== 0 || bad_gap) begin
      failures++; $display("FAIL stall_none got=%0d exp=0", stall_cyc.size()); end
`endif
  endtask

  task automatic test_random_jobs;
    logic [WIDTH-1:0] e;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) write_x(i, WIDTH'($urandom));
      fill_rx(0, 1'b1);
      do_job($urandom_range(0, 2), $urandom_range(0, 1), 1'b0, 1'b0, '0);
      checks++; if (timed_out || done_cnt !== 1) begin
        failures++; $display("FAIL rand%0d_done got=%0d exp=1", j, done_cnt); end
      checks++; if (hold_err !== 0 || rx_bad !== 0) begin
        failures++; $display("FAIL rand%0d_protocol got=hold%0d_rx%0d exp=0_0", j, hold_err, rx_bad); end
      for (int i = 0; i < got_tx.size() && exp_q.size() > 0; i++) begin
        e = exp_q.pop_front();
        checks++; if (got_tx[i] !== e) begin failures++; $display("FAIL rand%0d_tx%0d got=%0d exp=%0d", j, i, got_tx[i], e); end
      end
      for (int k = 0; k < M; k += 3) begin
        read_res(k);
        checks++; if (res_rdata !== res_m[k]) begin
          failures++; $display("FAIL rand%0d_res%0d got=%0d exp=%0d", j, k, res_rdata, res_m[k]); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_job();
    test_tx_backpressure();
    test_ignore_when_busy();
    test_reset_mid_send();
    test_write_with_start();
    test_rx_stall();
    test_random_jobs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fc_host_port.md
FC_HOST_PORT -- requirements
Module: fc_host_port

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits.
REQ-002 Parameter N, default 8: input vector length, in words sent per job.
REQ-003 Parameter M, default 10: output vector length, in words received per job.
REQ-004 clk  input  1  clock; all logic on posedge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 host_wr_en  input  1  host write strobe to x buffer.
REQ-007 host_addr  input  clog2(N)  x buffer write address.
REQ-008 host_wdata  input  WIDTH signed  x buffer write data.
REQ-009 start  input  1  job start request.
REQ-010 busy  output  1  job in progress.
REQ-011 done  output  1  one-cycle pulse at job completion.
REQ-012 tx_valid  output  1  tx_data valid toward accelerator input.
REQ-013 tx_ready  input  1  accelerator accepts tx_data.
REQ-014 tx_data  output  WIDTH signed  x word being sent.
REQ-015 rx_valid  input  1  accelerator output word valid.
REQ-016 rx_ready  output  1  port accepts rx_data.
REQ-017 rx_data  input  WIDTH signed  accelerator output word.
REQ-018 res_addr  input  clog2(M)  result buffer read address.
REQ-019 res_rdata  output  WIDTH signed  result word, registered, 1-cycle read latency.

Function
REQ-020 The FSM SHALL have states IDLE, SEND, RECV, DONE.
REQ-021 IDLE: start=1 -> SEND next cycle; tx index and rx index cleared to 0.
REQ-022 SEND: tx_valid=1, tx_data = x[tx index]; a transfer occurs on tx_valid&&tx_ready; the index increments per transfer.
REQ-023 SEND: after the N-th transfer -> RECV next cycle; tx_valid=0 that cycle; no (N+1)-th word is sent.
REQ-024 tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-025 RECV: rx_ready=1; on rx_valid&&rx_ready, rx_data is written to result[rx index]; the index increments.
REQ-026 RECV: after the M-th capture -> DONE; rx_ready=0 from that next cycle.
REQ-027 DONE: done=1 for exactly one cycle -> IDLE.
REQ-028 busy SHALL be 1 in SEND, RECV and DONE, and 0 in IDLE.
REQ-029 rx_ready SHALL be 0 outside RECV; rx_valid outside RECV is ignored, with no capture.
REQ-030 start outside IDLE SHALL be ignored.
REQ-031 host_wr_en SHALL write x only when busy=0; writes while busy=0 complete in one cycle; writes while busy=1 are dropped.
REQ-032 host_wr_en and start in the same IDLE cycle: the write SHALL land first; the job sends the new value.
REQ-033 Index counters SHALL not wrap beyond N-1 / M-1; the state transition occurs instead.
REQ-034 res_rdata SHALL be readable in any state; a read of an address written in the same cycle returns the old value.
REQ-035 Data SHALL pass through with no arithmetic, saturation or sign change.

Reset
REQ-036 On reset: state=IDLE; busy, done, tx_valid, rx_ready = 0; tx_data = 0; indices = 0.
REQ-037 Reset mid-SEND or mid-RECV SHALL abort the job in the next cycle with no done pulse.
REQ-038 x and result buffer contents SHALL NOT be cleared by reset.

Configuration
REQ-039 Macro FC_HOST_PORT_STALL_INJECT_EN defined: in RECV, rx_ready SHALL be forced to 0 every cycle where a free-running 2-bit counter (reset to 0) equals 3, giving 1 stall in 4.
REQ-040 Macro undefined: rx_ready follows REQ-025 and REQ-026 exactly; no stall counter is present.

Verification
REQ-041 Load x={1,2,...,8}, start, tx_ready=1 constantly -> tx_data 1..8 on 8 consecutive cycles, then tx_valid=0 and state RECV.
REQ-042 tx_ready toggling 1,0,1,0 during SEND -> each word is held while ready=0, exactly 8 transfers occur, and no word is skipped or duplicated.
REQ-043 Drive rx_data 100..109 with rx_valid=1 -> res_addr k reads 100+k one cycle later, and done pulses once after the 10th capture.
REQ-044 Assert start and host_wr_en(addr 3, -5) during RECV -> both ignored, and x[3] is unchanged on the next job.
REQ-045 Assert reset at the 5th tx transfer -> next cycle tx_valid=0 and busy=0, no done pulse, and a new start resends from x[0].
REQ-046 With FC_HOST_PORT_STALL_INJECT_EN and rx_valid held at 1 -> rx_ready is low 1 cycle in 4, and all 10 words are captured in order.
